// File: rtl/wb_write_sched_if.sv
// Handshake bundle between the W pipeline register and the write-back scheduler.
// The W stage is the master and drives the instruction; the scheduler answers with W_ready.
interface wb_write_sched_if #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 4
);
    logic              W_valid;
    logic              W_ready;
    logic [3:0]        W_in_code;
    logic              W_cnd;
    logic [REG_AW-1:0] W_dst_e;
    logic [REG_AW-1:0] W_dst_m;
    logic [DATA_W-1:0] W_val_e;
    logic [DATA_W-1:0] W_val_m;

    modport master (
        output W_valid,
        output W_in_code,
        output W_cnd,
        output W_dst_e,
        output W_dst_m,
        output W_val_e,
        output W_val_m,
        input  W_ready
    );

    modport slave (
        input  W_valid,
        input  W_in_code,
        input  W_cnd,
        input  W_dst_e,
        input  W_dst_m,
        input  W_val_e,
        input  W_val_m,
        output W_ready
    );
endinterface

// File: rtl/wb_write_sched.sv
// Write-back port scheduler: serialises the E and M writes of each retiring instruction
// onto the single register-file write port and keeps the retire/halt/bad-icode status.
//
// state    | meaning
// IDLE     | no write pending; ready to accept
// WR_FIRST | E-write on the port; M-write queued, W stalled
// WR_LAST  | final write of an instruction on the port; ready to accept
module wb_write_sched #(
    parameter int                DATA_W = 64,
    parameter int                REG_AW = 4,
    parameter logic [REG_AW-1:0] RNONE  = {REG_AW{1'b1}},
    parameter int                CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    wb_write_sched_if.slave   w,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_done,
    output logic [CNT_W-1:0]  retired,
    output logic              halted,
    output logic              bad_icode
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_FIRST = 2'd1,
        WR_LAST  = 2'd2
    } state_t;

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_CMOV   = 4'd2;
    localparam logic [3:0] I_IRMOV  = 4'd3;
    localparam logic [3:0] I_MRMOV  = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSH   = 4'd10;
    localparam logic [3:0] I_POP    = 4'd11;
    localparam logic [3:0] I_BAD_LO = 4'd12;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [REG_AW-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    logic accept;
    logic need_e;
    logic need_m;
    logic is_halt;
    logic is_bad;

    assign accept = w.W_valid && w.W_ready;

    // Destination decode for the instruction currently offered by W.
    always_comb begin
        need_e  = 1'b0;
        need_m  = 1'b0;
        is_halt = (w.W_in_code == I_HALT);
        is_bad  = (w.W_in_code >= I_BAD_LO);
        case (w.W_in_code)
            I_IRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP:
                need_e = (w.W_dst_e != RNONE);
            I_CMOV:
                need_e = w.W_cnd && (w.W_dst_e != RNONE);
            default:
                need_e = 1'b0;
        endcase
        if ((w.W_in_code == I_MRMOV) || (w.W_in_code == I_POP)) begin
            need_m = (w.W_dst_m != RNONE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            w.W_ready <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            wb_done   <= 1'b0;
            retired   <= '0;
            halted    <= 1'b0;
            bad_icode <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            rf_we   <= 1'b0;
            wb_done <= 1'b0;
            case (state)
                WR_FIRST: begin
                    rf_we     <= 1'b1;
                    rf_waddr  <= pend_addr;
                    rf_wdata  <= pend_data;
                    wb_done   <= 1'b1;
                    retired   <= retired + CNT_ONE;
                    state     <= WR_LAST;
                    w.W_ready <= ~halted;
                end
                IDLE, WR_LAST: begin
                    w.W_ready <= ~halted;
                    state     <= IDLE;
                    if (accept) begin
                        if (need_e && need_m) begin
                            // E goes first so a popq into its own stack pointer ends with the loaded value.
                            rf_we     <= 1'b1;
                            rf_waddr  <= w.W_dst_e;
                            rf_wdata  <= w.W_val_e;
                            pend_addr <= w.W_dst_m;
                            pend_data <= w.W_val_m;
                            state     <= WR_FIRST;
                            w.W_ready <= 1'b0;
                        end else begin
                            wb_done <= 1'b1;
                            retired <= retired + CNT_ONE;
                            if (need_e) begin
                                rf_we    <= 1'b1;
                                rf_waddr <= w.W_dst_e;
                                rf_wdata <= w.W_val_e;
                                state    <= WR_LAST;
                            end else if (need_m) begin
                                rf_we    <= 1'b1;
                                rf_waddr <= w.W_dst_m;
                                rf_wdata <= w.W_val_m;
                                state    <= WR_LAST;
                            end
                            if (is_halt) begin
                                halted    <= 1'b1;
                                w.W_ready <= 1'b0;
                            end
                            if (is_bad) begin
                                bad_icode <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    w.W_ready <= ~halted;
                end
            endcase
        end
    end

endmodule
